oam_dma_ctrl: RTL and testbench

//  Sprite DMA engine between the CPU core and the system bus. A CPU write to
//  DMA_REG_ADDR latches a source page P, stalls the CPU via cpu_rdy, and copies

---
 rtl/oam_dma_ctrl_if.sv | 23 ++
 rtl/oam_dma_ctrl.sv | 118 +++++++++++
 tb/tb_oam_dma_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/oam_dma_ctrl_if.sv
// CPU-side and system-bus-side signal bundle for the sprite DMA engine.
// slave is the DMA controller's view; master is the CPU/bus environment's view.
interface oam_dma_ctrl_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_r_nw;
  logic        cpu_rdy;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_r_nw;
  logic [7:0]  bus_rdata;
  logic        dma_active;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_r_nw, bus_rdata,
    output cpu_rdy, bus_addr, bus_wdata, bus_r_nw, dma_active
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_r_nw, bus_rdata,
    input  cpu_rdy, bus_addr, bus_wdata, bus_r_nw, dma_active
  );
endinterface

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA engine: a CPU write to DMA_REG_ADDR stalls the CPU and copies
// XFER_LEN bytes from page P to OAM_DATA_ADDR, owning the bus mux meanwhile.
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter int unsigned XFER_LEN      = 256
) (
  input  logic          clk_ph1,
  input  logic          rst,
  oam_dma_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = 9;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XFER_LEN - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HALT  = 3'd1;
  localparam logic [2:0] ST_ALIGN = 3'd2;
  localparam logic [2:0] ST_READ  = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [7:0]       page_q, page_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       data_lat_q, data_lat_d;
  logic             parity_q;
  logic             cpu_rdy_q;
  logic             dma_active_q;

  logic [15:0]      bus_addr_c;
  logic [7:0]       bus_wdata_c;
  logic             bus_r_nw_c;
  logic             trigger_c;

  // Triggers are only honoured from IDLE, so a stray write mid-transfer cannot reload page.
  assign trigger_c = (state_q == ST_IDLE) && !bus.cpu_r_nw && (bus.cpu_addr == DMA_REG_ADDR);

  // Next-state, datapath next values and bus mux.
  always_comb begin
    state_d     = state_q;
    page_d      = page_q;
    count_d     = count_q;
    data_lat_d  = data_lat_q;
    bus_addr_c  = bus.cpu_addr;
    bus_wdata_c = bus.cpu_wdata;
    bus_r_nw_c  = bus.cpu_r_nw;

    case (state_q)
      ST_IDLE: begin
        if (trigger_c) begin
          page_d  = bus.cpu_wdata;
          count_d = '0;
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        bus_wdata_c = 8'h00;
        bus_r_nw_c  = 1'b1;
        // parity_q==1 now means the next cycle is even, which is where READs must land.
        state_d     = parity_q ? ST_READ : ST_ALIGN;
      end
      ST_ALIGN: begin
        bus_wdata_c = 8'h00;
        bus_r_nw_c  = 1'b1;
        state_d     = ST_READ;
      end
      ST_READ: begin
        bus_addr_c  = {page_q, count_q[7:0]};
        bus_wdata_c = 8'h00;
        bus_r_nw_c  = 1'b1;
        data_lat_d  = bus.bus_rdata;
        state_d     = ST_WRITE;
      end
      ST_WRITE: begin
        bus_addr_c  = OAM_DATA_ADDR;
        bus_wdata_c = data_lat_q;
        bus_r_nw_c  = 1'b0;
        if (count_q == LAST_CNT) begin
          state_d = ST_IDLE;
        end else begin
          count_d = count_q + CNT_W'(1);
          state_d = ST_READ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and status flops; status bits are precomputed from state_d.
  always_ff @(posedge clk_ph1 or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      page_q       <= 8'h00;
      count_q      <= '0;
      data_lat_q   <= 8'h00;
      parity_q     <= 1'b0;
      cpu_rdy_q    <= 1'b1;
      dma_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      page_q       <= page_d;
      count_q      <= count_d;
      data_lat_q   <= data_lat_d;
      parity_q     <= ~parity_q;
      cpu_rdy_q    <= (state_d == ST_IDLE);
      dma_active_q <= (state_d != ST_IDLE);
    end
  end

  assign bus.cpu_rdy    = cpu_rdy_q;
  assign bus.dma_active = dma_active_q;
  assign bus.bus_addr   = bus_addr_c;
  assign bus.bus_wdata  = bus_wdata_c;
  assign bus.bus_r_nw   = bus_r_nw_c;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: full 256-byte transfers on both cycle
// parities, register decode, mid-transfer reset and a 4-byte back-to-back case.
module tb_oam_dma_ctrl;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   cyc;

  oam_dma_ctrl_if ifa ();
  oam_dma_ctrl_if ifb ();

  oam_dma_ctrl #(.XFER_LEN(256)) dut_a (.clk_ph1(clk), .rst(rst), .bus(ifa));
  oam_dma_ctrl #(.XFER_LEN(4))   dut_b (.clk_ph1(clk), .rst(rst), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index since reset release; its LSB is the expected cycle parity.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    case (a)
      16'h0700: return 8'h11;
      16'h0701: return 8'h22;
      16'h0702: return 8'h33;
      16'h0703: return 8'h44;
      default:  return a[7:0] ^ a[15:8] ^ 8'hA5;
    endcase
  endfunction

  assign ifa.bus_rdata = mem_rd(ifa.bus_addr);
  assign ifb.bus_rdata = mem_rd(ifb.bus_addr);

  task automatic test_reset();
    rst = 1'b0;
    ifa.cpu_addr = 16'h1234; ifa.cpu_wdata = 8'h00; ifa.cpu_r_nw = 1'b1;
    ifb.cpu_addr = 16'h8123; ifb.cpu_wdata = 8'h00; ifb.cpu_r_nw = 1'b1;
    #300;
    total++;
    if (ifa.cpu_rdy !== 1'b1 || ifa.dma_active !== 1'b0) begin
      bad++; $display("FAIL reset_status: got rdy=%b act=%b want rdy=1 act=0", ifa.cpu_rdy, ifa.dma_active);
    end
    total++;
    if (ifa.bus_addr !== 16'h1234 || ifa.bus_r_nw !== 1'b1) begin
      bad++; $display("FAIL reset_pass1: got addr=%h rnw=%b want addr=1234 rnw=1", ifa.bus_addr, ifa.bus_r_nw);
    end
    ifa.cpu_addr = 16'hABCD; ifa.cpu_wdata = 8'h5A; ifa.cpu_r_nw = 1'b0;
    #299;
    total++;
    if (ifa.bus_addr !== 16'hABCD || ifa.bus_r_nw !== 1'b0 || ifa.bus_wdata !== 8'h5A) begin
      bad++; $display("FAIL reset_pass2: got addr=%h rnw=%b wd=%h want addr=abcd rnw=0 wd=5a",
                      ifa.bus_addr, ifa.bus_r_nw, ifa.bus_wdata);
    end
    total++;
    if (ifb.cpu_rdy !== 1'b1 || ifb.dma_active !== 1'b0) begin
      bad++; $display("FAIL reset_status_b: got rdy=%b act=%b want rdy=1 act=0", ifb.cpu_rdy, ifb.dma_active);
    end
    ifa.cpu_addr = 16'h8123; ifa.cpu_wdata = 8'h00; ifa.cpu_r_nw = 1'b1;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Full 256-byte transfer from page $02; trig_odd picks the trigger cycle parity.
  task automatic test_full_xfer(input bit trig_odd);
    int n, stall, align, idx, rel;
    bit done;
    @(posedge clk); #1;
    if (cyc[0] != trig_odd) begin @(posedge clk); #1; end
    n = cyc;
    align = (n % 2 == 1) ? 1 : 0;
    ifa.cpu_addr = 16'h4014; ifa.cpu_wdata = 8'h02; ifa.cpu_r_nw = 1'b0;
    #1;
    total++;
    if (ifa.bus_addr !== 16'h4014 || ifa.bus_r_nw !== 1'b0 || ifa.bus_wdata !== 8'h02 || ifa.cpu_rdy !== 1'b1) begin
      bad++; $display("FAIL trig_pass: got addr=%h rnw=%b wd=%h rdy=%b want 4014/0/02/1",
                      ifa.bus_addr, ifa.bus_r_nw, ifa.bus_wdata, ifa.cpu_rdy);
    end
    @(posedge clk); #1;
    ifa.cpu_addr = 16'h8123; ifa.cpu_wdata = 8'h00; ifa.cpu_r_nw = 1'b1;
    stall = 0; done = 0;
    for (int k = 0; k < 600 && !done; k++) begin
      #1;
      if (ifa.cpu_rdy === 1'b1) begin
        done = 1;
      end else begin
        stall++;
        if (k < 1 + align) begin
          total++;
          if (ifa.bus_addr !== 16'h8123 || ifa.bus_r_nw !== 1'b1 || ifa.bus_wdata !== 8'h00 || ifa.dma_active !== 1'b1) begin
            bad++; $display("FAIL halt_drive k=%0d: got addr=%h rnw=%b wd=%h act=%b want 8123/1/00/1",
                            k, ifa.bus_addr, ifa.bus_r_nw, ifa.bus_wdata, ifa.dma_active);
          end
        end else begin
          rel = k - 1 - align;
          idx = rel / 2;
          total++;
          if (rel % 2 == 0) begin
            if (ifa.bus_addr !== {8'h02, idx[7:0]} || ifa.bus_r_nw !== 1'b1 || cyc[0] !== 1'b0) begin
              bad++; $display("FAIL read_cyc idx=%0d: got addr=%h rnw=%b par=%0d want addr=%h rnw=1 par=0",
                              idx, ifa.bus_addr, ifa.bus_r_nw, cyc % 2, {8'h02, idx[7:0]});
            end
          end else begin
            if (ifa.bus_addr !== 16'h2004 || ifa.bus_r_nw !== 1'b0 || ifa.bus_wdata !== mem_rd({8'h02, idx[7:0]})) begin
              bad++; $display("FAIL write_cyc idx=%0d: got addr=%h rnw=%b wd=%h want addr=2004 rnw=0 wd=%h",
                              idx, ifa.bus_addr, ifa.bus_r_nw, ifa.bus_wdata, mem_rd({8'h02, idx[7:0]}));
            end
          end
        end
        @(posedge clk); #1;
      end
    end
    total++;
    if (!done) begin
      bad++; $display("FAIL full_timeout: got still stalled after 600 cycles want cpu_rdy=1");
    end
    total++;
    if (stall != 513 + align) begin
      bad++; $display("FAIL stall_len odd=%0b: got %0d want %0d", trig_odd, stall, 513 + align);
    end
    total++;
    if (ifa.dma_active !== 1'b0 || ifa.bus_addr !== 16'h8123 || ifa.bus_r_nw !== 1'b1) begin
      bad++; $display("FAIL full_end: got act=%b addr=%h rnw=%b want 0/8123/1", ifa.dma_active, ifa.bus_addr, ifa.bus_r_nw);
    end
  endtask

  task automatic test_reg_decode();
    @(posedge clk); #1;
    ifa.cpu_addr = 16'h4014; ifa.cpu_wdata = 8'h03; ifa.cpu_r_nw = 1'b1;
    #1;
    total++;
    if (ifa.bus_addr !== 16'h4014 || ifa.bus_r_nw !== 1'b1) begin
      bad++; $display("FAIL rd4014_pass: got addr=%h rnw=%b want 4014/1", ifa.bus_addr, ifa.bus_r_nw);
    end
    @(posedge clk); #1;
    ifa.cpu_addr = 16'h4015; ifa.cpu_wdata = 8'h33; ifa.cpu_r_nw = 1'b0;
    #1;
    total++;
    if (ifa.cpu_rdy !== 1'b1 || ifa.dma_active !== 1'b0) begin
      bad++; $display("FAIL rd4014_idle: got rdy=%b act=%b want 1/0", ifa.cpu_rdy, ifa.dma_active);
    end
    total++;
    if (ifa.bus_addr !== 16'h4015 || ifa.bus_r_nw !== 1'b0 || ifa.bus_wdata !== 8'h33) begin
      bad++; $display("FAIL wr4015_pass: got addr=%h rnw=%b wd=%h want 4015/0/33", ifa.bus_addr, ifa.bus_r_nw, ifa.bus_wdata);
    end
    @(posedge clk); #1;
    ifa.cpu_addr = 16'h8123; ifa.cpu_wdata = 8'h00; ifa.cpu_r_nw = 1'b1;
    repeat (2) begin
      #1;
      total++;
      if (ifa.cpu_rdy !== 1'b1 || ifa.dma_active !== 1'b0) begin
        bad++; $display("FAIL wr4015_idle: got rdy=%b act=%b want 1/0", ifa.cpu_rdy, ifa.dma_active);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    ifa.cpu_addr = 16'h4014; ifa.cpu_wdata = 8'h05; ifa.cpu_r_nw = 1'b0;
    @(posedge clk); #1;
    ifa.cpu_addr = 16'h8123; ifa.cpu_wdata = 8'h00; ifa.cpu_r_nw = 1'b1;
    repeat (99) @(posedge clk);
    #2;
    total++;
    if (ifa.dma_active !== 1'b1 || ifa.cpu_rdy !== 1'b0) begin
      bad++; $display("FAIL mid_active: got act=%b rdy=%b want 1/0", ifa.dma_active, ifa.cpu_rdy);
    end
    #1;
    rst = 1'b0;
    #1;
    total++;
    if (ifa.cpu_rdy !== 1'b1 || ifa.dma_active !== 1'b0 || ifa.bus_r_nw !== 1'b1 || ifa.bus_addr !== 16'h8123) begin
      bad++; $display("FAIL mid_reset: got rdy=%b act=%b rnw=%b addr=%h want 1/0/1/8123",
                      ifa.cpu_rdy, ifa.dma_active, ifa.bus_r_nw, ifa.bus_addr);
    end
    for (int k = 0; k < 10; k++) begin
      if (k == 5) begin @(negedge clk); rst = 1'b1; end
      @(posedge clk); #2;
      total++;
      if ((ifa.bus_r_nw === 1'b0 && ifa.bus_addr === 16'h2004) || ifa.cpu_rdy !== 1'b1) begin
        bad++; $display("FAIL post_reset k=%0d: got addr=%h rnw=%b rdy=%b want no 2004 write, rdy=1",
                        k, ifa.bus_addr, ifa.bus_r_nw, ifa.cpu_rdy);
      end
    end
  endtask

  // 4-byte transfer from page $07, retriggered in the cycle it returns to IDLE.
  task automatic test_back_to_back();
    logic [7:0] exp4 [0:3];
    int align, stall, wn;
    bit done;
    exp4[0] = 8'h11; exp4[1] = 8'h22; exp4[2] = 8'h33; exp4[3] = 8'h44;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) begin @(posedge clk); #1; end
      align = (cyc % 2 == 1) ? 1 : 0;
      ifb.cpu_addr = 16'h4014; ifb.cpu_wdata = 8'h07; ifb.cpu_r_nw = 1'b0;
      #1;
      total++;
      if (ifb.bus_addr !== 16'h4014 || ifb.bus_r_nw !== 1'b0 || ifb.bus_wdata !== 8'h07 || ifb.cpu_rdy !== 1'b1) begin
        bad++; $display("FAIL b2b_trig pass=%0d: got addr=%h rnw=%b wd=%h rdy=%b want 4014/0/07/1",
                        pass, ifb.bus_addr, ifb.bus_r_nw, ifb.bus_wdata, ifb.cpu_rdy);
      end
      @(posedge clk); #1;
      ifb.cpu_addr = 16'h8123; ifb.cpu_wdata = 8'h00; ifb.cpu_r_nw = 1'b1;
      stall = 0; wn = 0; done = 0;
      for (int k = 0; k < 40 && !done; k++) begin
        #1;
        if (ifb.cpu_rdy === 1'b1) begin
          done = 1;
        end else begin
          stall++;
          if (ifb.bus_r_nw === 1'b0 && ifb.bus_addr === 16'h2004) begin
            total++;
            if (wn > 3 || ifb.bus_wdata !== exp4[wn[1:0]]) begin
              bad++; $display("FAIL short_wr n=%0d: got wd=%h want %h within 4 writes", wn, ifb.bus_wdata, exp4[wn[1:0]]);
            end
            wn++;
          end
          @(posedge clk); #1;
        end
      end
      total++;
      if (!done || wn != 4) begin
        bad++; $display("FAIL short_count pass=%0d: got done=%0b writes=%0d want done=1 writes=4", pass, done, wn);
      end
      total++;
      if (stall != 9 + align) begin
        bad++; $display("FAIL short_stall pass=%0d: got %0d want %0d", pass, stall, 9 + align);
      end
    end
    total++;
    if (ifb.dma_active !== 1'b0 || ifb.bus_addr !== 16'h8123) begin
      bad++; $display("FAIL short_end: got act=%b addr=%h want 0/8123", ifb.dma_active, ifb.bus_addr);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_full_xfer(1'b0);
    test_full_xfer(1'b1);
    test_reg_decode();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
